mem_arbiter: RTL

Two-port sequencing controller for the 8-word x 8-bit latch memory (decoder + mem_word array + NAND8 read tree). It arbitrates between two requesters in round-robin order, latches the winning request, and drives the memory address, read/write and valid strobe with explicit setup, strobe and hold phases. The latch array is therefore only ever addressed with stable signals. The block replaces direct bench or FSM driving of the memory and sits between system requesters and the memory array.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 93 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter_if : requester and latch-memory bus bundle for mem_arbiter   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface mem_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              req0;
    logic              req1;
    logic              op0;
    logic              op1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt, ack0, ack1, rdata, busy, mem_addr, mem_rw, mem_valid, mem_wdata
    );

    // Requesters plus memory array side
    modport master (
        output req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt, ack0, ack1, rdata, busy, mem_addr, mem_rw, mem_valid, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter : round-robin two-port sequencer for the 8x8 latch memory    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 3,
    parameter int STROBE_CYCLES = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_arbiter_if.slave    bus
);

    localparam int             CNT_W    = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t           state;
    logic             last_served;
    logic [CNT_W-1:0] strobe_cnt;
    logic             pick1;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last
    assign pick1 = bus.req1 && (!bus.req0 || !last_served);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_served   <= 1'b1;
            strobe_cnt    <= '0;
            bus.gnt       <= 2'b00;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rdata     <= '0;
            bus.mem_addr  <= '0;
            bus.mem_rw    <= 1'b0;
            bus.mem_valid <= 1'b0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state         <= SETUP;
                        bus.busy      <= 1'b1;
                        bus.gnt       <= pick1 ? 2'b10 : 2'b01;
                        bus.mem_rw    <= pick1 ? bus.op1    : bus.op0;
                        bus.mem_addr  <= pick1 ? bus.addr1  : bus.addr0;
                        bus.mem_wdata <= pick1 ? bus.wdata1 : bus.wdata0;
                    end
                end
                SETUP: begin
                    state         <= STROBE;
                    bus.mem_valid <= 1'b1;
                    strobe_cnt    <= '0;
                end
                STROBE: begin
                    if (strobe_cnt == CNT_LAST) begin
                        state         <= HOLD;
                        bus.mem_valid <= 1'b0;
                        bus.ack0      <= bus.gnt[0];
                        bus.ack1      <= bus.gnt[1];
                        if (!bus.mem_rw) begin
                            bus.rdata <= bus.mem_rdata;
                        end
                    end else begin
                        strobe_cnt <= strobe_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Address/rw/data stay driven so the latch sees a clean hold phase
                    state       <= IDLE;
                    bus.ack0    <= 1'b0;
                    bus.ack1    <= 1'b0;
                    bus.gnt     <= 2'b00;
                    bus.busy    <= 1'b0;
                    last_served <= bus.gnt[1];
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
